hls_deadlock_report_collector: RTL and testbench
================================================

// Module: hls_deadlock_report_collector
// PURPOSE
//  Consumer end of the per-instance HLS deadlock monitors: takes their 1-bit 'block' outputs,
//  confirms a deadlock only after it persists CONFIRM_CYCLES consecutive cycles, snapshots which
//  monitors are blocked plus a timestamp, and delivers one report over a valid/ready handshake.
//  Sits at the top of a FINN stitched design next to the dataflow region; feeds a debug/IRQ block.
// PARAMETERS
//  NUM_MON         4     number of monitor 'block' inputs collected
//  CONFIRM_CYCLES  1024  consecutive cycles any block must stay high before a report (>=1)
//  TS_W            32    width of free-running timestamp and report_ts
// PORTS
//  clock         in   1         single clock, all logic rising-edge
//  reset_n       in   1         asynchronous, active-low reset
//  mon_block     in   NUM_MON   block outputs of the deadlock monitors, one per instance
//  report_valid  out  1         report available
//  report_ready  in   1         consumer accepts report when valid&ready
//  report_mask   out  NUM_MON   mon_block snapshot on the confirming cycle
//  report_ts     out  TS_W      timestamp value on the confirming cycle
//  deadlock_cnt  out  8         number of reports issued, saturates at 255
//  irq_clear     in   1         clears sticky irq (STICKY variant only; ignored otherwise)
//  deadlock_irq  out  1         interrupt to host
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, all outputs 0, timestamp=0, persistence counter=0.
//  - Timestamp: free-running, +1 per cycle from first cycle after reset release; wraps mod 2^TS_W.
//  - any_blk = |mon_block. Inputs are sampled once per cycle, no synchroniser (same clock domain).
//  - FSM:
//    IDLE:    pcnt=0. any_blk=1 -> SUSPECT, pcnt=1.
//    SUSPECT: any_blk=0 -> IDLE, pcnt=0 (any gap restarts persistence).
//             any_blk=1 & pcnt==CONFIRM_CYCLES-1 -> REPORT; capture report_mask=mon_block,
//             report_ts=timestamp, deadlock_cnt+=1 (sat 255); else pcnt+=1.
//             CONFIRM_CYCLES=1: IDLE goes straight to REPORT on first any_blk cycle, same capture.
//    REPORT:  report_valid=1; mask/ts stable while valid. valid&ready -> DRAIN, valid=0 next cycle.
//    DRAIN:   waits for any_blk=0 (deadlock dissolved / reset of dataflow) -> IDLE.
//             Guarantees exactly one report per continuous deadlock episode.
//  - Latency: report_valid rises CONFIRM_CYCLES cycles after first any_blk=1 cycle (counting
//    that cycle as 1) when no gap occurs.
//  - Set bits of mon_block changing during SUSPECT do not restart counting; only any_blk matters.
//  - report_ready while not REPORT: ignored. ready already high on entry to REPORT: accept in
//    the first valid cycle (valid high exactly 1 cycle).
//  - mon_block dropping during REPORT: report still held until accepted; then DRAIN exits next cycle.
//  - reset_n asserted mid-report: report lost, outputs 0 immediately (async), deadlock_cnt=0.
//  - pcnt width = $clog2(CONFIRM_CYCLES+1); never exceeds CONFIRM_CYCLES-1.
// CONFIGURATION
//  HLS_DEADLOCK_STICKY_IRQ_EN defined: deadlock_irq set on the cycle entering REPORT, stays 1
//    until irq_clear=1 (cleared next edge); set and clear in same cycle -> set wins.
//  Not defined: deadlock_irq == report_valid (combinational copy of the registered valid);
//    irq_clear unused.
// TESTING
//  1 NUM_MON=4,CONFIRM_CYCLES=8: mon_block=4'b0010 for 8 cycles -> valid rises on cycle 8,
//    report_mask=4'b0010, report_ts=capture timestamp, deadlock_cnt=1.
//  2 mon_block high 7 cycles, low 1, high 8 -> no report after first burst; report after the
//    8th cycle of second burst; cnt=1.
//  3 report_ready=0 for 20 cycles after valid -> valid, mask, ts stable; ready=1 -> valid
//    low next cycle; block still high -> stays DRAIN, no second report; block low -> IDLE.
//  4 Two episodes separated by all-zero cycle -> two reports, cnt=2; 260 episodes -> cnt=255.
//  5 reset_n pulse low while report_valid=1 -> all outputs 0 asynchronously, FSM IDLE.
//  6 STICKY_EN built: irq stays 1 after handshake until irq_clear; clear coinciding with a new
//    REPORT entry -> irq remains 1. Without macro: irq tracks report_valid exactly.

Source files
------------

// File: rtl/hls_deadlock_report_collector.sv
`default_nettype none
// ============================================================================
//  Module   : hls_deadlock_report_collector
//  Purpose  : Confirms a persistent deadlock from the per-instance monitor
//             block flags and issues one timestamped report per episode.
//  Options  : HLS_DEADLOCK_STICKY_IRQ_EN - sticky interrupt with irq_clear.
//  Revision : 1.0 - initial release
// ============================================================================
module hls_deadlock_report_collector #(
  parameter int NUM_MON        = 4,
  parameter int CONFIRM_CYCLES = 1024,
  parameter int TS_W           = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [NUM_MON-1:0] report_mask,
  output logic [TS_W-1:0]    report_ts,
  output logic [7:0]         deadlock_cnt,
  input  logic               irq_clear,
  output logic               deadlock_irq
);

  localparam int                PCNT_W    = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [TS_W-1:0]   TS_ONE    = TS_W'(1);
  localparam logic [7:0]        CNT_ONE   = 8'd1;
  localparam logic [7:0]        CNT_MAX   = 8'hFF;
  localparam bit                SINGLE    = (CONFIRM_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_REPORT  = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [TS_W-1:0]    rts_q, rts_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               any_blk;
  logic               capture;

  always_comb begin
    any_blk = |mon_block;
    ts_d    = ts_q + TS_ONE;
    state_d = state_q;
    pcnt_d  = pcnt_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        pcnt_d = '0;
        if (any_blk) begin
          if (SINGLE) begin
            capture = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            pcnt_d  = PCNT_ONE;
          end
        end
      end
      S_SUSPECT: begin
        // Any idle cycle means the dataflow made progress: restart persistence.
        if (!any_blk) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end else if (pcnt_q == PCNT_LAST) begin
          capture = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PCNT_ONE;
        end
      end
      S_REPORT: begin
        if (report_ready) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!any_blk) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
      end
    endcase

    if (capture) begin
      state_d = S_REPORT;
      pcnt_d  = '0;
    end

    valid_d = (state_d == S_REPORT);
    mask_d  = capture ? mon_block : mask_q;
    rts_d   = capture ? ts_q : rts_q;
    cnt_d   = (capture && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      ts_q    <= '0;
      mask_q  <= '0;
      rts_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ts_q    <= ts_d;
      mask_q  <= mask_d;
      rts_q   <= rts_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign report_valid = valid_q;
  assign report_mask  = mask_q;
  assign report_ts    = rts_q;
  assign deadlock_cnt = cnt_q;

`ifdef HLS_DEADLOCK_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // A new report outranks a simultaneous clear so no episode goes unsignalled.
  always_comb begin
    irq_d = irq_q;
    if (capture) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign deadlock_irq = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = irq_clear;
  assign deadlock_irq     = valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hls_deadlock_report_collector.sv
`default_nettype none
// Directed testbench for hls_deadlock_report_collector (NUM_MON=4, CONFIRM_CYCLES=8).
module tb_hls_deadlock_report_collector;

  logic        clock;
  logic        reset_n;
  logic [3:0]  mon_block;
  logic        report_valid;
  logic        report_ready;
  logic [3:0]  report_mask;
  logic [31:0] report_ts;
  logic [7:0]  deadlock_cnt;
  logic        irq_clear;
  logic        deadlock_irq;

  int          n_checks;
  int          n_fail;
  logic [31:0] cyc;
  logic [31:0] exp_ts;
  logic [7:0]  exp_cnt;

  hls_deadlock_report_collector #(
    .NUM_MON(4), .CONFIRM_CYCLES(8), .TS_W(32)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mon_block(mon_block),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_mask(report_mask), .report_ts(report_ts),
    .deadlock_cnt(deadlock_cnt), .irq_clear(irq_clear),
    .deadlock_irq(deadlock_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference timestamp: edges seen since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 32'd0;
    else          cyc <= cyc + 32'd1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mon_block = 4'b0; report_ready = 1'b0; irq_clear = 1'b0;
    exp_cnt = 8'd0;
    tick(3);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", report_valid); end
    n_checks++; if (report_mask !== 4'b0) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", report_mask); end
    n_checks++; if (report_ts !== 32'd0) begin n_fail++; $display("FAIL reset_ts: got %0d want 0", report_ts); end
    n_checks++; if (deadlock_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", deadlock_cnt); end
    n_checks++; if (deadlock_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", deadlock_irq); end
    reset_n = 1'b1;
    tick(3);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", report_valid); end
  endtask

  task automatic test_basic;
    mon_block = 4'b0010;
    exp_ts = cyc + 32'd7;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: cycle %0d got %b want 0", i, report_valid); end
    end
    tick(1);
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", report_valid); end
    n_checks++; if (report_mask !== 4'b0010) begin n_fail++; $display("FAIL basic_mask: got %b want 0010", report_mask); end
    n_checks++; if (report_ts !== exp_ts) begin n_fail++; $display("FAIL basic_ts: got %0d want %0d", report_ts, exp_ts); end
    n_checks++; if (deadlock_cnt !== exp_cnt) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", deadlock_cnt, exp_cnt); end
    report_ready = 1'b1; mon_block = 4'b0;
    tick(1);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %b want 0", report_valid); end
    report_ready = 1'b0;
    tick(1);
  endtask

  // Gap restarts persistence; then hold the report and check it stays in DRAIN.
  task automatic test_gap_and_hold;
    mon_block = 4'b1000;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL gap_first_burst: cycle %0d got %b want 0", i, report_valid); end
    end
    mon_block = 4'b0000;
    tick(1);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL gap_low: got %b want 0", report_valid); end
    mon_block = 4'b0100;
    exp_ts = cyc + 32'd7;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 3) mon_block = 4'b0110;
      n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL gap_second_burst: cycle %0d got %b want 0", i, report_valid); end
    end
    tick(1);
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", report_valid); end
    n_checks++; if (report_mask !== 4'b0110) begin n_fail++; $display("FAIL gap_mask: got %b want 0110", report_mask); end
    n_checks++; if (report_ts !== exp_ts) begin n_fail++; $display("FAIL gap_ts: got %0d want %0d", report_ts, exp_ts); end
    mon_block = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_checks++; if (report_valid !== 1'b1 || report_mask !== 4'b0110 || report_ts !== exp_ts)
        begin n_fail++; $display("FAIL hold_stable: cycle %0d got v=%b m=%b ts=%0d want v=1 m=0110 ts=%0d", i, report_valid, report_mask, report_ts, exp_ts); end
    end
    report_ready = 1'b1;
    tick(1);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL hold_accept: got %b want 0", report_valid); end
    report_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_checks++; if (report_valid !== 1'b0 || deadlock_cnt !== exp_cnt)
        begin n_fail++; $display("FAIL drain_no_report: cycle %0d got v=%b cnt=%0d want v=0 cnt=%0d", i, report_valid, deadlock_cnt, exp_cnt); end
    end
    mon_block = 4'b0000;
    tick(1);
  endtask

  // Episodes with ready held high: valid lasts exactly one cycle; count saturates.
  task automatic test_saturation;
    report_ready = 1'b1;
    for (int e = 0; e < 260; e++) begin
      mon_block = 4'b0001;
      tick(8);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL ep_valid: episode %0d got %b want 1", e, report_valid); end
      n_checks++; if (deadlock_cnt !== exp_cnt) begin n_fail++; $display("FAIL ep_cnt: episode %0d got %0d want %0d", e, deadlock_cnt, exp_cnt); end
      mon_block = 4'b0000;
      tick(1);
      n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL ep_one_cycle: episode %0d got %b want 0", e, report_valid); end
      tick(1);
    end
    n_checks++; if (deadlock_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", deadlock_cnt); end
    report_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    mon_block = 4'b1001;
    tick(8);
    n_checks++; if (report_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", report_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (report_valid !== 1'b0 || report_mask !== 4'b0 || report_ts !== 32'd0 || deadlock_cnt !== 8'd0 || deadlock_irq !== 1'b0)
      begin n_fail++; $display("FAIL async_reset: got v=%b m=%b ts=%0d cnt=%0d irq=%b want all 0", report_valid, report_mask, report_ts, deadlock_cnt, deadlock_irq); end
    mon_block = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    exp_cnt = 8'd0;
    tick(1);
    mon_block = 4'b0100;
    exp_ts = cyc + 32'd7;
    tick(7);
    n_checks++; if (report_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_early: got %b want 0", report_valid); end
    tick(1);
    n_checks++; if (report_valid !== 1'b1 || deadlock_cnt !== 8'd1 || report_ts !== exp_ts)
      begin n_fail++; $display("FAIL post_rst_report: got v=%b cnt=%0d ts=%0d want v=1 cnt=1 ts=%0d", report_valid, deadlock_cnt, report_ts, exp_ts); end
    report_ready = 1'b1; mon_block = 4'b0000;
    tick(2);
    report_ready = 1'b0;
  endtask

  task automatic test_irq;
    mon_block = 4'b0010;
    irq_clear = 1'b0;
    tick(7);
    n_checks++; if (deadlock_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", deadlock_irq); end
    tick(1);
    n_checks++; if (deadlock_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", deadlock_irq); end
    report_ready = 1'b1; mon_block = 4'b0000;
    tick(1);
    report_ready = 1'b0;
`ifdef HLS_DEADLOCK_STICKY_IRQ_EN
    tick(3);
    n_checks++; if (deadlock_irq !== 1'b1) begin n_fail++; $display("FAIL irq_sticky: got %b want 1", deadlock_irq); end
    irq_clear = 1'b1;
    tick(1);
    irq_clear = 1'b0;
    n_checks++; if (deadlock_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", deadlock_irq); end
    mon_block = 4'b0001;
    irq_clear = 1'b1;
    tick(8);
    n_checks++; if (deadlock_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", deadlock_irq); end
    irq_clear = 1'b0;
    report_ready = 1'b1; mon_block = 4'b0000;
    tick(2);
    report_ready = 1'b0;
`else
    n_checks++; if (deadlock_irq !== 1'b0) begin n_fail++; $display("FAIL irq_follow_valid: got %b want 0", deadlock_irq); end
    irq_clear = 1'b1;
    tick(2);
    irq_clear = 1'b0;
    n_checks++; if (deadlock_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_ignored: got %b want 0", deadlock_irq); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_gap_and_hold();
    test_saturation();
    test_async_reset();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
